store_buffer: RTL and testbench

Four-entry FIFO store buffer between the MEM stage of the pipelined MIPS core and the word-addressed data memory. Retired `sw` operations enqueue here in one cycle, and the buffer drains them to memory one write at a time under a memory acknowledge. While entries are pending, `lw` addresses are checked against the buffer and the youngest matching store is forwarded, so loads never read stale memory.

---
 rtl/store_buffer_pkg.sv | 23 ++
 rtl/sb_fwd_match.sv | 36 +++
 rtl/store_buffer.sv | 98 +++++++++
 tb/tb_store_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared constants and helper types for the MEM-stage store buffer.
// Word-address slicing and the default depth live here so the core agrees on them.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int WORD_LO   = 2;
    localparam int WORD_HI   = SB_ADDR_W - 1;

    // Per-cycle queue activity; encoded as {dequeue, enqueue}.
    typedef enum logic [1:0] {
        SB_IDLE = 2'b00,
        SB_ENQ  = 2'b01,
        SB_DEQ  = 2'b10,
        SB_BOTH = 2'b11
    } sb_op_e;

    function automatic sb_op_e sb_op(input logic enq, input logic deq);
        return sb_op_e'({deq, enq});
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: finds the youngest valid entry whose word address
// matches the load and returns its data.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH  = SB_DEPTH,
    parameter  int WORD_W = SB_ADDR_W - WORD_LO,
    parameter  int DATA_W = SB_DATA_W,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic [WORD_W-1:0] ent_addr [DEPTH],
    input  logic [DATA_W-1:0] ent_data [DEPTH],
    input  logic [PW-1:0]     hd,
    input  logic [PW:0]       count,
    input  logic [WORD_W-1:0] ld_word,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overrides an older one.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = hd;
        for (int k = 0; k < DEPTH; k++) begin
            idx = hd + PW'(k);
            if (((PW + 1)'(k) < count) && (ent_addr[idx] == ld_word)) begin
                ld_hit  = 1'b1;
                ld_data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Four-entry FIFO store buffer between the MEM stage and word-addressed data memory.
// Drains one write per memory acknowledge and forwards pending stores to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              empty
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CNT_W  = PW + 1;
    localparam int WORD_W = ADDR_W - WORD_LO;

    logic [PW-1:0]     hd;
    logic [PW-1:0]     tl;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic   full;
    logic   enq;
    logic   deq;
    sb_op_e op;
    logic   unused_byte_bits;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full buffer refuses stores even when the head drains this cycle, keeping
    // st_ready free of any path from mem_ack.
    assign st_ready = !full;
    assign enq      = st_valid && st_ready;
    assign deq      = mem_we && mem_ack;
    assign op       = sb_op(enq, deq);

    assign mem_we    = !empty;
    assign mem_addr  = {ent_addr[hd], {WORD_LO{1'b0}}};
    assign mem_wdata = ent_data[hd];

    assign unused_byte_bits = ^{st_addr[WORD_LO-1:0], ld_addr[WORD_LO-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hd    <= '0;
            tl    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (enq) begin
                ent_addr[tl] <= st_addr[ADDR_W-1:WORD_LO];
                ent_data[tl] <= st_data;
                tl           <= tl + PW'(1);
            end
            if (deq) begin
                hd <= hd + PW'(1);
            end
            case (op)
                SB_ENQ:  count <= count + CNT_W'(1);
                SB_DEQ:  count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .hd       (hd),
        .count    (count),
        .ld_word  (ld_addr[ADDR_W-1:WORD_LO]),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue model of pending stores predicts
// occupancy, forwarding and the order of memory writes.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        empty;

    typedef struct {
        logic [29:0] word;
        logic [31:0] data;
    } ent_t;

    ent_t model[$];
    ent_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .empty     (empty)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    // Compare all outputs visible this cycle against the queue model.
    task automatic checkOutput();
        logic        exp_hit;
        logic [31:0] exp_ld;
        exp_hit = 1'b0;
        exp_ld  = '0;
        for (int i = model.size() - 1; i >= 0; i--) begin
            if (model[i].word == ld_addr[31:2]) begin
                exp_hit = 1'b1;
                exp_ld  = model[i].data;
                break;
            end
        end
        check("st_ready", 32'(st_ready), 32'(model.size() < DEPTH));
        check("empty", 32'(empty), 32'(model.size() == 0));
        check("mem_we", 32'(mem_we), 32'(model.size() > 0));
        if (model.size() > 0) begin
            check("mem_addr_head", mem_addr, {model[0].word, 2'b00});
            check("mem_wdata_head", mem_wdata, model[0].data);
        end
        check("ld_hit", 32'(ld_hit), 32'(exp_hit));
        check("ld_data", ld_data, exp_ld);
    endtask

    // One clock of stimulus: drive at negedge, check, then advance the model.
    task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic ack, input logic [31:0] la);
        logic acc;
        logic dq;
        ent_t e;
        @(negedge clk);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        mem_ack  = ack;
        ld_addr  = la;
        #1;
        checkOutput();
        acc = sv && (model.size() < DEPTH);
        dq  = ack && (model.size() > 0);
        if (dq) void'(model.pop_front());
        if (acc) begin
            e.word = sa[31:2];
            e.data = sd;
            model.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic applyReset(input int n);
        @(negedge clk);
        rst_n    = 1'b0;
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        model.delete();
        exp_q.delete();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && model.size() > 0; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        end
        @(negedge clk);
        #3;
        check("drain_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    // Monitor: every accepted memory write must match the next expected store.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && mem_we === 1'b1 && mem_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_we), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, {e.word, 2'b00});
                    check("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc_count;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        mem_ack  = 1'b0;
        ld_addr  = '0;

        applyReset(2);
        check("reset_ld_hit", 32'(ld_hit), 32'd0);

        // Single store reaches memory the next cycle and drains on ack.
        applyStimulus(1'b1, 32'h10, 32'hAA, 1'b0, 32'h10);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
        check("single_mem_addr", mem_addr, 32'h10);
        check("single_mem_wdata", mem_wdata, 32'hAA);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("single_empty_after_ack", 32'(empty), 32'd1);

        // Fill, then a fifth store is refused even while the head drains.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, 32'h0);
        end
        applyStimulus(1'b1, 32'h80, 32'h555, 1'b1, 32'h80);
        check("full_st_ready", 32'(st_ready), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h80);
        check("after_full_st_ready", 32'(st_ready), 32'd1);
        check("rejected_not_visible", 32'(ld_hit), 32'd0);
        drain();

        // Youngest of two stores to the same word wins.
        applyStimulus(1'b1, 32'h20, 32'd1, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h24, 32'd2, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h20, 32'd3, 1'b0, 32'h20);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h22);
        check("fwd_youngest_hit", 32'(ld_hit), 32'd1);
        check("fwd_youngest_data", ld_data, 32'd3);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h30);
        check("fwd_miss_data", ld_data, 32'd0);
        drain();

        // Ten stores with toggling ack exercise pointer wrap and drain order.
        acc_count = 0;
        for (int i = 0; i < 60 && acc_count < 10; i++) begin
            if (model.size() < DEPTH) begin
                applyStimulus(1'b1, 32'h200 + 32'(4 * acc_count), 32'hC000 + 32'(acc_count),
                              1'(i % 2), 32'h200);
                acc_count++;
            end else begin
                applyStimulus(1'b1, 32'h300, 32'hDEAD, 1'(i % 2), 32'h200);
            end
        end
        check("wrap_accepted", 32'(acc_count), 32'd10);
        drain();

        // Reset with entries pending discards them.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h60 + 32'(4 * i), 32'h700 + 32'(i), 1'b0, 32'h0);
        end
        applyReset(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h60);
        end

        // Randomised traffic over a small address pool to provoke forwarding.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          32'h400 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                          $urandom,
                          1'($urandom_range(0, 2) != 0),
                          32'h400 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
